// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: access FSM states and requester identities.
package dmem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. req[0] is the CPU and req[1] is the loader.
// On a tie, the requester that did not own the memory last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       win_valid,
  output logic       win_id
);

  assign win_valid = |req;
  assign win_id    = (req == 2'b11) ? ~last_owner : req[1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU datapath and the loader port.
// A three-state access FSM issues one access at a time and steers read data back to its owner.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_rvalid,
  output logic              ldr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_lastOwner;

  logic              w_winValid;
  logic              w_winId;
  logic              w_inAccess;
  logic              w_inResp;
  logic              w_ownerIsLdr;
  logic              w_ownerReq;
  logic              w_ownerWe;
  logic [ADDR_W-1:0] w_ownerAddr;
  logic [DATA_W-1:0] w_ownerWdata;
  logic              w_cpuDone;

  rr_arb2 u_rrArb (
    .req        ({ldr_req, cpu_req}),
    .last_owner (r_lastOwner),
    .win_valid  (w_winValid),
    .win_id     (w_winId)
  );

  // Reset starts with the loader as last owner so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_CPU;
      r_lastOwner <= OWN_LDR;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_winValid) begin
            r_owner <= w_winId;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_ownerReq) begin
            r_lastOwner <= r_owner;
            r_state     <= w_ownerWe ? IDLE : RESP;
          end else begin
            r_state <= IDLE;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_inAccess   = (r_state == ACCESS);
  assign w_inResp     = (r_state == RESP);
  assign w_ownerIsLdr = (r_owner == OWN_LDR);
  assign w_ownerReq   = w_ownerIsLdr ? ldr_req   : cpu_req;
  assign w_ownerWe    = w_ownerIsLdr ? ldr_we    : cpu_we;
  assign w_ownerAddr  = w_ownerIsLdr ? ldr_addr  : cpu_addr;
  assign w_ownerWdata = w_ownerIsLdr ? ldr_wdata : cpu_wdata;

  // A requester that dropped its request before grant gets no memory cycle at all.
  assign mem_en    = w_inAccess & w_ownerReq;
  assign mem_we    = mem_en & w_ownerWe;
  assign mem_addr  = w_inAccess ? w_ownerAddr  : '0;
  assign mem_wdata = w_inAccess ? w_ownerWdata : '0;

  assign cpu_gnt    = mem_en & ~w_ownerIsLdr;
  assign ldr_gnt    = mem_en &  w_ownerIsLdr;
  assign cpu_rvalid = w_inResp & ~w_ownerIsLdr;
  assign ldr_rvalid = w_inResp &  w_ownerIsLdr;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : '0;

  // Stall is masked by reset so every output reads 0 while reset is held.
  assign w_cpuDone = (w_inAccess & ~w_ownerIsLdr & cpu_req & cpu_we) | cpu_rvalid;
  assign cpu_stall = rst & cpu_req & ~w_cpuDone;

endmodule
